// File: rtl/i2c_apb_pkg.sv
// ============================================================================
// Module : i2c_apb_pkg
// Brief  : Register map, bit indices and command-entry layout for the
//          APB front-end of the I2C master.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package i2c_apb_pkg;

    localparam int OFF_CTRL    = 'h00;
    localparam int OFF_CMD     = 'h04;
    localparam int OFF_REGADDR = 'h08;
    localparam int OFF_RDATA   = 'h0C;
    localparam int OFF_STATUS  = 'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 2;

    localparam int ST_BUSY     = 0;
    localparam int ST_CMD_FULL = 1;
    localparam int ST_CMD_EMPT = 2;
    localparam int ST_RD_EMPT  = 3;
    localparam int ST_RD_FULL  = 4;
    localparam int ST_NACK     = 5;
    localparam int ST_RD_OVF   = 6;
    localparam int ST_TIMEOUT  = 7;

    // Channel field is sized for the largest supported NUM_CH (4).
    typedef struct packed {
        logic [1:0]  ch;
        logic        bit_ctrl;
        logic        rh_wl;
        logic [7:0]  sladdr;
        logic [15:0] regaddr;
        logic [7:0]  wdata;
    } cmd_entry_t;

    localparam int CMD_W = $bits(cmd_entry_t);

endpackage

`default_nettype wire

// File: rtl/i2c_apb_sync_fifo.sv
// ============================================================================
// Module : i2c_apb_sync_fifo
// Brief  : Single-clock FIFO with flush; push into full / pop from empty ignored.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_apb_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;
    assign data_o  = mem_q[rptr_q];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    // Flush outranks any push/pop presented in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (w_push) wptr_q <= wptr_q + AW'(1);
            if (w_pop)  rptr_q <= rptr_q + AW'(1);
            case ({w_push, w_pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_master_apb_ctrl.sv
// ============================================================================
// Module : i2c_master_apb_ctrl
// Brief  : APB3 slave front-end for the I2C master engine (CMD/RD FIFOs,
//          sticky status, level irq). Optional watchdog: I2C_APB_TIMEOUT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_master_apb_ctrl
    import i2c_apb_pkg::*;
#(
    parameter int APB_AW      = 12,
    parameter int CMD_DEPTH   = 8,
    parameter int RD_DEPTH    = 8,
    parameter int NUM_CH      = 2,
    parameter int TIMEOUT_CYC = 65535,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic            i_apb_pclk,
    input  logic            i_apb_prst,
    input  logic            i_apb_psel,
    input  logic            i_apb_penable,
    input  logic            i_apb_pwrite,
    input  logic [31:0]     i_apb_paddr,
    input  logic [31:0]     i_apb_pwdata,
    output logic            o_apb_pready,
    output logic [31:0]     o_apb_prdata,
    output logic            o_apb_pslverr,
    output logic            o_cmd_valid,
    input  logic            i_cmd_ready,
    output logic [CH_W-1:0] o_cmd_ch,
    output logic            o_cmd_bit_ctrl,
    output logic            o_cmd_rh_wl,
    output logic [7:0]      o_cmd_sladdr,
    output logic [15:0]     o_cmd_regaddr,
    output logic [7:0]      o_cmd_wdata,
    input  logic [7:0]      i_i2c_rdata,
    input  logic            i_i2c_rvalid,
    input  logic            i_i2c_done,
    input  logic            i_i2c_nack,
    input  logic            i_i2c_busy,
    output logic            o_eng_abort,
    output logic            o_irq
);

    localparam int CLVL_W = $clog2(CMD_DEPTH) + 1;
    localparam int RLVL_W = $clog2(RD_DEPTH) + 1;

    logic              en_q, irq_en_q, nack_q, rd_ovf_q, irq_q;
    logic              nack_d, rd_ovf_d, irq_d;
    logic [15:0]       regaddr_q;
    logic              w_access, w_wr, w_rd, w_mapped, w_ch_bad, w_flush;
    logic              w_sel_ctrl, w_sel_cmd, w_sel_reg, w_sel_rdata, w_sel_status;
    logic              w_cmd_push, w_cmd_pop, w_cmd_flush, w_cmd_full, w_cmd_empty;
    logic              w_rd_pop, w_rd_full, w_rd_empty;
    logic              w_timeout, w_tmo_fire, w_unused;
    logic [2:0]        w_w1c;
    logic [APB_AW-1:0] w_off;
    logic [CLVL_W-1:0] w_cmd_level;
    logic [RLVL_W-1:0] w_rd_level_unused;
    logic [7:0]        w_rd_head;
    logic [15:0]       w_status;
    cmd_entry_t        w_cmd_in, w_cmd_head;

    assign w_access     = i_apb_psel & i_apb_penable;
    assign w_wr         = w_access & i_apb_pwrite;
    assign w_rd         = w_access & ~i_apb_pwrite;
    assign w_off        = i_apb_paddr[APB_AW-1:0];
    assign w_sel_ctrl   = (w_off == APB_AW'(OFF_CTRL));
    assign w_sel_cmd    = (w_off == APB_AW'(OFF_CMD));
    assign w_sel_reg    = (w_off == APB_AW'(OFF_REGADDR));
    assign w_sel_rdata  = (w_off == APB_AW'(OFF_RDATA));
    assign w_sel_status = (w_off == APB_AW'(OFF_STATUS));
    assign w_mapped     = w_sel_ctrl | w_sel_cmd | w_sel_reg | w_sel_rdata | w_sel_status;
    assign w_ch_bad     = ({30'd0, i_apb_pwdata[21:20]} >= 32'(NUM_CH));

    assign w_cmd_push   = w_wr & w_sel_cmd & ~w_cmd_full & ~w_ch_bad;
    assign w_cmd_pop    = o_cmd_valid & i_cmd_ready;
    assign w_flush      = w_wr & w_sel_ctrl & i_apb_pwdata[CTRL_FLUSH];
    assign w_cmd_flush  = w_flush | w_tmo_fire;
    assign w_rd_pop     = w_rd & w_sel_rdata & ~w_rd_empty;
    assign w_w1c        = (w_wr & w_sel_status) ? i_apb_pwdata[7:5] : 3'b000;

    assign w_cmd_in.ch       = i_apb_pwdata[21:20];
    assign w_cmd_in.bit_ctrl = i_apb_pwdata[17];
    assign w_cmd_in.rh_wl    = i_apb_pwdata[16];
    assign w_cmd_in.sladdr   = i_apb_pwdata[15:8];
    assign w_cmd_in.regaddr  = regaddr_q;
    assign w_cmd_in.wdata    = i_apb_pwdata[7:0];

    i2c_apb_sync_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(CMD_W)) u_cmd_fifo (
        .clk_i   (i_apb_pclk),
        .rst_i   (i_apb_prst),
        .flush_i (w_cmd_flush),
        .push_i  (w_cmd_push),
        .data_i  (w_cmd_in),
        .pop_i   (w_cmd_pop),
        .data_o  (w_cmd_head),
        .full_o  (w_cmd_full),
        .empty_o (w_cmd_empty),
        .level_o (w_cmd_level)
    );

    i2c_apb_sync_fifo #(.DEPTH(RD_DEPTH), .WIDTH(8)) u_rd_fifo (
        .clk_i   (i_apb_pclk),
        .rst_i   (i_apb_prst),
        .flush_i (w_flush),
        .push_i  (i_i2c_rvalid),
        .data_i  (i_i2c_rdata),
        .pop_i   (w_rd_pop),
        .data_o  (w_rd_head),
        .full_o  (w_rd_full),
        .empty_o (w_rd_empty),
        .level_o (w_rd_level_unused)
    );

    assign o_cmd_valid    = en_q & ~w_cmd_empty;
    assign o_cmd_ch       = w_cmd_head.ch[CH_W-1:0];
    assign o_cmd_bit_ctrl = w_cmd_head.bit_ctrl;
    assign o_cmd_rh_wl    = w_cmd_head.rh_wl;
    assign o_cmd_sladdr   = w_cmd_head.sladdr;
    assign o_cmd_regaddr  = w_cmd_head.regaddr;
    assign o_cmd_wdata    = w_cmd_head.wdata;

    assign w_status = {8'(w_cmd_level), w_timeout, rd_ovf_q, nack_q, w_rd_full,
                       w_rd_empty, w_cmd_empty, w_cmd_full, i_i2c_busy | ~w_cmd_empty};

    assign o_apb_pready  = 1'b1;
    assign o_apb_pslverr = w_access & (~w_mapped | (i_apb_pwrite & w_sel_cmd & (w_cmd_full | w_ch_bad)));
    assign o_irq         = irq_q;

    always_comb begin
        o_apb_prdata = 32'd0;
        if (w_rd) begin
            if (w_sel_ctrl)   o_apb_prdata = {30'd0, irq_en_q, en_q};
            if (w_sel_reg)    o_apb_prdata = {16'd0, regaddr_q};
            if (w_sel_rdata && !w_rd_empty) o_apb_prdata = {23'd0, 1'b1, w_rd_head};
            if (w_sel_status) o_apb_prdata = {16'd0, w_status};
        end
    end

    // Sticky bits: a new event in the same cycle as W1C keeps the bit set.
    assign nack_d   = (nack_q & ~w_w1c[0]) | (i_i2c_done & i_i2c_nack);
    assign rd_ovf_d = (rd_ovf_q & ~w_w1c[1]) | (i_i2c_rvalid & w_rd_full);
    assign irq_d    = irq_en_q & (nack_q | rd_ovf_q | w_timeout | ~w_rd_empty);

    always_ff @(posedge i_apb_pclk) begin
        if (i_apb_prst) begin
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            regaddr_q <= 16'd0;
            nack_q    <= 1'b0;
            rd_ovf_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            if (w_wr && w_sel_ctrl) begin
                en_q     <= i_apb_pwdata[CTRL_EN];
                irq_en_q <= i_apb_pwdata[CTRL_IRQ_EN];
            end
            if (w_wr && w_sel_reg) regaddr_q <= i_apb_pwdata[15:0];
            nack_q   <= nack_d;
            rd_ovf_q <= rd_ovf_d;
            irq_q    <= irq_d;
        end
    end

`ifdef I2C_APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q;
    logic             tmo_q, abort_q;

    assign w_tmo_fire  = i_i2c_busy & ~i_i2c_done & (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
    assign w_timeout   = tmo_q;
    assign o_eng_abort = abort_q;

    always_ff @(posedge i_apb_pclk) begin
        if (i_apb_prst) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            abort_q <= w_tmo_fire;
            tmo_q   <= (tmo_q & ~w_w1c[2]) | w_tmo_fire;
            if (w_tmo_fire || i_i2c_done || !i_i2c_busy) tmo_cnt_q <= '0;
            else                                         tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
        end
    end
`else
    assign w_tmo_fire  = 1'b0;
    assign w_timeout   = 1'b0;
    assign o_eng_abort = 1'b0;
`endif

    assign w_unused = ^{i_apb_paddr[31:APB_AW], i_apb_pwdata[31:22], i_apb_pwdata[19:18],
                        w_cmd_head.ch, w_rd_level_unused, w_w1c, (TIMEOUT_CYC != 0)};

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_apb_ctrl.sv
// ============================================================================
// Module : tb_i2c_master_apb_ctrl
// Brief  : Directed + random bench with a queue-based model of the front-end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2c_master_apb_ctrl;

    localparam int DEPTH = 8;
    localparam int TCYC  = 16;

    logic        clk = 1'b0, rst = 1'b1;
    logic        psel = 0, penable = 0, pwrite = 0;
    logic [31:0] paddr = 0, pwdata = 0;
    logic        cmd_ready = 0, rvalid = 0, done = 0, nack = 0, i2c_busy = 0;
    logic [7:0]  rdata = 0;

    logic        pready, pslverr, cmd_valid, bit_ctrl, rh_wl, abort, irq;
    logic [31:0] prdata;
    logic [0:0]  cmd_ch;
    logic [7:0]  sladdr, wdata;
    logic [15:0] regaddr;

    i2c_master_apb_ctrl #(.APB_AW(12), .CMD_DEPTH(DEPTH), .RD_DEPTH(DEPTH),
                          .NUM_CH(2), .TIMEOUT_CYC(TCYC)) dut (
        .i_apb_pclk(clk), .i_apb_prst(rst), .i_apb_psel(psel), .i_apb_penable(penable),
        .i_apb_pwrite(pwrite), .i_apb_paddr(paddr), .i_apb_pwdata(pwdata),
        .o_apb_pready(pready), .o_apb_prdata(prdata), .o_apb_pslverr(pslverr),
        .o_cmd_valid(cmd_valid), .i_cmd_ready(cmd_ready), .o_cmd_ch(cmd_ch),
        .o_cmd_bit_ctrl(bit_ctrl), .o_cmd_rh_wl(rh_wl), .o_cmd_sladdr(sladdr),
        .o_cmd_regaddr(regaddr), .o_cmd_wdata(wdata), .i_i2c_rdata(rdata),
        .i_i2c_rvalid(rvalid), .i_i2c_done(done), .i_i2c_nack(nack), .i_i2c_busy(i2c_busy),
        .o_eng_abort(abort), .o_irq(irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    // Model: command entry = {ch[1:0], bit_ctrl, rh_wl, sladdr[7:0], regaddr[15:0], wdata[7:0]}
    logic [35:0] m_cmd[$];
    logic [7:0]  m_rd[$];
    bit          m_en, m_irq_en, m_nack, m_ovf, m_tmo, m_irq, m_abort;
    logic [15:0] m_regaddr;
    int          m_tcnt;
    logic [31:0] act_prdata;
    logic        act_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'd0;
        s[0] = i2c_busy || (m_cmd.size() > 0);
        s[1] = (m_cmd.size() == DEPTH);
        s[2] = (m_cmd.size() == 0);
        s[3] = (m_rd.size() == 0);
        s[4] = (m_rd.size() == DEPTH);
        s[5] = m_nack;
        s[6] = m_ovf;
        s[7] = m_tmo;
        s[15:8] = 8'(m_cmd.size());
        return s;
    endfunction

    function automatic void m_reset();
        m_cmd.delete(); m_rd.delete();
        m_en = 0; m_irq_en = 0; m_nack = 0; m_ovf = 0; m_tmo = 0; m_irq = 0; m_abort = 0;
        m_regaddr = 16'd0; m_tcnt = 0;
    endfunction

    // One clock: compare before the edge, then advance the model on the edge.
    task automatic step();
        logic [31:0] e_prdata;
        bit          e_err, acc, fire, flush, cpop, cpush, rpop, rpush, irq_n;
        logic [2:0]  w1c;
        int          off;
        #3;
        acc = psel && penable;
        off = int'(paddr[11:0]);
        e_prdata = 32'd0;
        e_err = 0;
        if (acc) begin
            case (off)
                'h00: if (!pwrite) e_prdata = {30'd0, m_irq_en, m_en};
                'h04: if (pwrite && (m_cmd.size() >= DEPTH || pwdata[21:20] >= 2)) e_err = 1;
                'h08: if (!pwrite) e_prdata = {16'd0, m_regaddr};
                'h0C: if (!pwrite && m_rd.size() > 0) e_prdata = {23'd0, 1'b1, m_rd[0]};
                'h10: if (!pwrite) e_prdata = m_status();
                default: e_err = 1;
            endcase
        end
        act_prdata = prdata;
        act_err    = pslverr;
        if (!rst) begin
            chk("prdata", prdata, e_prdata);
            chk("pslverr", pslverr, e_err);
            chk("pready", pready, 1);
            chk("cmd_valid", cmd_valid, m_en && m_cmd.size() > 0);
            if (m_en && m_cmd.size() > 0)
                chk("cmd_fields", {cmd_ch, bit_ctrl, rh_wl, sladdr, regaddr, wdata},
                    {m_cmd[0][34:0]});
            chk("irq", irq, m_irq);
            chk("abort", abort, m_abort);
        end
        @(posedge clk);
        if (rst) begin
            m_reset();
        end else begin
            fire = 0;
`ifdef I2C_APB_TIMEOUT_EN
            if (i2c_busy && !done) begin
                if (m_tcnt == TCYC - 1) begin fire = 1; m_tcnt = 0; end
                else m_tcnt++;
            end else m_tcnt = 0;
`endif
            flush = acc && pwrite && off == 'h00 && pwdata[2];
            irq_n = m_irq_en && (m_nack || m_ovf || m_tmo || m_rd.size() > 0);
            cpop  = m_en && m_cmd.size() > 0 && cmd_ready;
            cpush = acc && pwrite && off == 'h04 && m_cmd.size() < DEPTH && pwdata[21:20] < 2;
            rpop  = acc && !pwrite && off == 'h0C && m_rd.size() > 0;
            rpush = rvalid && m_rd.size() < DEPTH;
            w1c   = (acc && pwrite && off == 'h10) ? pwdata[7:5] : 3'b000;
            m_ovf  = (m_ovf && !w1c[1]) || (rvalid && m_rd.size() == DEPTH);
            m_nack = (m_nack && !w1c[0]) || (done && nack);
            m_tmo  = (m_tmo && !w1c[2]) || fire;
            if (flush || fire) m_cmd.delete();
            else begin
                if (cpop) void'(m_cmd.pop_front());
                if (cpush) m_cmd.push_back({pwdata[21:20], pwdata[17], pwdata[16],
                                            pwdata[15:8], m_regaddr, pwdata[7:0]});
            end
            if (flush) m_rd.delete();
            else begin
                if (rpop) void'(m_rd.pop_front());
                if (rpush) m_rd.push_back(rdata);
            end
            if (acc && pwrite && off == 'h00) begin m_en = pwdata[0]; m_irq_en = pwdata[1]; end
            if (acc && pwrite && off == 'h08) m_regaddr = pwdata[15:0];
            m_irq   = irq_n;
            m_abort = fire;
        end
        @(negedge clk);
    endtask

    task automatic apb(input bit wr, input logic [31:0] a, input logic [31:0] d);
        psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
        step();
        penable = 1;
        step();
        psel = 0; penable = 0; pwrite = 0;
    endtask

    initial begin
        int n;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();
        chk("rst_valid", cmd_valid, 0);
        chk("rst_irq", irq, 0);
        chk("rst_prdata", act_prdata, 0);
        chk("rst_pslverr", act_err, 0);
        chk("rst_abort", abort, 0);
        rst = 0;
        step();

        // Single command issue
        apb(1, 'h00, 1);
        apb(1, 'h08, 'h1234);
        cmd_ready = 1;
        apb(1, 'h04, 32'h0003_50A5);
        chk("issue_valid", cmd_valid, 1);
        chk("issue_fields", {cmd_ch, bit_ctrl, rh_wl, sladdr, regaddr, wdata},
            {1'b0, 1'b1, 1'b1, 8'h50, 16'h1234, 8'hA5});
        step();
        chk("issue_once", cmd_valid, 0);
        cmd_ready = 0;

        // Fill CMD FIFO with issue stalled
        apb(1, 'h00, 0);
        for (int i = 0; i < 9; i++) begin
            apb(1, 'h04, 32'h0000_1100 + i);
            chk("fill_err", act_err, (i == 8));
        end
        apb(0, 'h10, 0);
        chk("fill_level", act_prdata[15:8], 8);
        chk("fill_full", act_prdata[1], 1);
        apb(1, 'h00, 4);
        apb(0, 'h10, 0);
        chk("flush_empty", act_prdata[2], 1);

        // Read-data path and irq
        apb(1, 'h00, 2);
        rvalid = 1; rdata = 8'h3C; step();
        rdata = 8'h7E; step();
        rvalid = 0; step();
        chk("irq_rd", irq, 1);
        apb(0, 'h0C, 0); chk("rdata0", act_prdata, 32'h13C);
        apb(0, 'h0C, 0); chk("rdata1", act_prdata, 32'h17E);
        apb(0, 'h0C, 0); chk("rdata_empty", act_prdata, 0);
        step();
        chk("irq_drop", irq, 0);

        // Overflow
        rvalid = 1;
        for (int i = 0; i < 9; i++) begin rdata = 8'(i); step(); end
        rvalid = 0; step();
        apb(0, 'h10, 0);
        chk("ovf_set", act_prdata[6], 1);
        chk("ovf_full", act_prdata[4], 1);
        chk("ovf_irq", irq, 1);
        apb(1, 'h10, 'h40);
        apb(0, 'h10, 0);
        chk("ovf_clr", act_prdata[6], 0);
        apb(1, 'h00, 6);

        // NACK, set-beats-clear, bad channel, unmapped
        done = 1; nack = 1; step(); done = 0; nack = 0;
        apb(0, 'h10, 0);
        chk("nack_set", act_prdata[5], 1);
        psel = 1; pwrite = 1; paddr = 'h10; pwdata = 'h20; step();
        penable = 1; done = 1; nack = 1; step();
        psel = 0; penable = 0; done = 0; nack = 0;
        apb(0, 'h10, 0);
        chk("nack_set_wins", act_prdata[5], 1);
        apb(1, 'h10, 'h20);
        apb(0, 'h10, 0);
        chk("nack_clr", act_prdata[5], 0);
        apb(1, 'h04, 32'h0030_0000);
        chk("bad_ch_err", act_err, 1);
        apb(0, 'h10, 0);
        chk("bad_ch_nopush", act_prdata[15:8], 0);
        apb(0, 'h20, 0);
        chk("unmapped_err", act_err, 1);

        // Watchdog
        apb(1, 'h00, 0);
        apb(1, 'h04, 32'h0000_2233);
        i2c_busy = 1;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (abort && n == 0) n = i;
        end
        i2c_busy = 0;
        step();
        apb(0, 'h10, 0);
`ifdef I2C_APB_TIMEOUT_EN
        chk("tmo_cycle", n, TCYC);
        chk("tmo_flag", act_prdata[7], 1);
        chk("tmo_cmd_empty", act_prdata[2], 1);
`else
        chk("tmo_none", n, 0);
        chk("tmo_flag0", act_prdata[7], 0);
`endif
        apb(1, 'h00, 4);
        apb(1, 'h10, 'hE0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int sel;
            psel    = ($urandom_range(0, 3) != 0);
            penable = ($urandom_range(0, 3) != 0);
            pwrite  = $urandom_range(0, 1) == 1;
            sel     = $urandom_range(0, 7);
            case (sel)
                0: paddr = 'h00;  1, 2: paddr = 'h04;  3: paddr = 'h08;
                4: paddr = 'h0C;  5: paddr = 'h10;  6: paddr = 'h20;
                default: paddr = 32'($urandom_range(0, 1023)) << 2;
            endcase
            pwdata = $urandom;
            if (paddr == 'h00) begin
                pwdata[0] = ($urandom_range(0, 3) != 0);
                pwdata[2] = ($urandom_range(0, 15) == 0);
            end
            cmd_ready = $urandom_range(0, 2) == 0;
            rvalid    = $urandom_range(0, 2) == 0;
            rdata     = 8'($urandom);
            done      = $urandom_range(0, 7) == 0;
            nack      = $urandom_range(0, 1) == 1;
            i2c_busy  = $urandom_range(0, 7) != 0;
            step();
        end
        psel = 0; penable = 0; rvalid = 0; done = 0; i2c_busy = 0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
